// File: rtl/uart_tx_feeder_if.sv
// Producer write port and uart handshake bundle for uart_tx_feeder.
interface uart_tx_feeder_if #(
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [7:0]        wr_data;
   logic              full;
   logic              empty;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              Tx_busy;
   logic              Tx_wr;
   logic [7:0]        Tx_data;
   logic [15:0]       tx_sent;

   modport master (
      output wr_en, wr_data, Tx_busy,
      input  full, empty, count, overflow, Tx_wr, Tx_data, tx_sent
   );

   modport slave (
      input  wr_en, wr_data, Tx_busy,
      output full, empty, count, overflow, Tx_wr, Tx_data, tx_sent
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that paces single-cycle Tx_wr pulses to a uart on Tx_busy.
// Define UART_TX_FEEDER_STATS_EN to count completed transfers on tx_sent.
module uart_tx_feeder #(
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int ACK_TIMEOUT = 16
) (
   input logic             clk,
   input logic             reset,
   uart_tx_feeder_if.slave bus
);
   localparam int                TW           = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [ADDR_W:0]   FULL_COUNT   = (ADDR_W + 1)'(DEPTH);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] REQ       = 2'd1;
   localparam logic [1:0] WAIT_ACK  = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [1:0]        state;
   logic [TW-1:0]     tcnt;
   logic [7:0]        tx_data;
   logic              overflow;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   assign full  = (count == FULL_COUNT);
   assign empty = (count == '0);
   assign pop   = (state == WAIT_ACK) && bus.Tx_busy;
   // A full FIFO still takes a write in the same cycle its head is acknowledged.
   assign push  = bus.wr_en && (!full || pop);

   // NOTE: the byte storage is deliberately not reset; count/pointers define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.wr_data;
   end

   // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (bus.wr_en && !push) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         tcnt    <= '0;
         tx_data <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               // Another source may hold the uart busy; wait for it to free up.
               if (!empty && !bus.Tx_busy) begin
                  tx_data <= mem[rd_ptr];
                  state   <= REQ;
               end
            end
            REQ: begin
               tcnt  <= '0;
               state <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (bus.Tx_busy)               state <= WAIT_DONE;
               else if (tcnt == TIMEOUT_LAST) state <= REQ;
               else                           tcnt  <= tcnt + 1'b1;
            end
            WAIT_DONE: begin
               if (!bus.Tx_busy) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_TX_FEEDER_STATS_EN
   logic [15:0] tx_sent;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sent <= 16'h0000;
      end else if (state == WAIT_DONE && !bus.Tx_busy && tx_sent != 16'hFFFF) begin
         tx_sent <= tx_sent + 1'b1;
      end
   end

   assign bus.tx_sent = tx_sent;
`else
   assign bus.tx_sent = 16'h0000;
`endif

   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count;
   assign bus.overflow = overflow;
   assign bus.Tx_wr    = (state == REQ);
   assign bus.Tx_data  = tx_data;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: transaction-level FIFO model plus a
// behavioural uart that acknowledges Tx_wr pulses after a programmable delay.
module tb_uart_tx_feeder;
   localparam int DEPTH       = 8;
   localparam int ADDR_W      = 3;
   localparam int ACK_TIMEOUT = 16;

   localparam int U_IDLE  = 0;
   localparam int U_DELAY = 1;
   localparam int U_BUSY  = 2;
   localparam int U_SPUR  = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

   uart_tx_feeder #(
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      bit         wr_en;
      logic [7:0] wr_data;
      int         exp_count;
      bit         exp_full;
      bit         exp_empty;
      bit         exp_ovf;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q[$];
   logic [7:0] obs[$];
   bit         m_overflow;
   int         m_sent;
   int         u_st;
   int         u_cnt;
   logic [7:0] cur_byte;
   int         cfg_delay;
   int         cfg_len;
   bit         no_ack;
   bit         force_busy;
   bit         spur_en;
   bit         chk_interval;
   int         cyc;
   int         pulses;
   int         last_pulse;
   bit         prev_wr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_sent();
`ifdef UART_TX_FEEDER_STATS_EN
      return (m_sent > 65535) ? 16'hFFFF : 16'(m_sent);
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      m_overflow = 1'b0;
      m_sent     = 0;
      u_st       = U_IDLE;
      u_cnt      = 0;
      prev_wr    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"},    bus.count, 0);
      check({tag, "_empty"},    bus.empty, 1);
      check({tag, "_full"},     bus.full, 0);
      check({tag, "_overflow"}, bus.overflow, 0);
      check({tag, "_tx_wr"},    bus.Tx_wr, 0);
      check({tag, "_tx_data"},  bus.Tx_data, 8'h00);
      check({tag, "_tx_sent"},  bus.tx_sent, 16'h0000);
   endtask

   // One clock: check outputs, run the uart model, update the FIFO model, drive.
   task automatic tick(input bit we, input logic [7:0] wd);
      bit busy;
      bit pop;
      bit acc;
      int u_was;
      busy  = 1'b0;
      pop   = 1'b0;
      acc   = 1'b0;
      u_was = u_st;

      check("count", bus.count, q.size());
      check("empty", bus.empty, q.size() == 0);
      check("full", bus.full, q.size() == DEPTH);
      check("overflow", bus.overflow, m_overflow);
      check("tx_sent", bus.tx_sent, exp_sent());
      if (u_st == U_DELAY || u_st == U_BUSY) check("tx_data_stable", bus.Tx_data, cur_byte);

      if (force_busy) begin
         busy = 1'b1;
      end else begin
         case (u_st)
            U_DELAY: begin
               u_cnt--;
               if (u_cnt == 0) begin
                  busy  = 1'b1;
                  pop   = 1'b1;
                  u_st  = U_BUSY;
                  u_cnt = (cfg_len != 0) ? cfg_len : int'($urandom_range(6, 1));
               end
            end
            U_BUSY: begin
               u_cnt--;
               if (u_cnt == 0) begin
                  u_st = U_IDLE;
                  m_sent++;
               end else begin
                  busy = 1'b1;
               end
            end
            U_SPUR: begin
               u_cnt--;
               if (u_cnt == 0) u_st = U_IDLE;
               else            busy = 1'b1;
            end
            default: begin
               if (spur_en && !bus.Tx_wr && $urandom_range(9) == 0) begin
                  busy  = 1'b1;
                  u_st  = U_SPUR;
                  u_cnt = int'($urandom_range(4, 1));
               end
            end
         endcase
      end

      if (bus.Tx_wr) begin
         pulses++;
         check("tx_wr_gap", prev_wr, 0);
         check("tx_wr_while_xfer", u_was, U_IDLE);
         if (q.size() != 0) check("tx_data", bus.Tx_data, q[0]);
         else               check("tx_data_no_pending", bus.Tx_data, 9'h100);
         obs.push_back(bus.Tx_data);
         if (chk_interval && last_pulse >= 0) check("retry_interval", cyc - last_pulse, ACK_TIMEOUT + 1);
         last_pulse = cyc;
         if (u_was == U_IDLE && !no_ack && q.size() != 0) begin
            u_st     = U_DELAY;
            u_cnt    = (cfg_delay != 0) ? cfg_delay : int'($urandom_range(3, 1));
            cur_byte = q[0];
         end
      end
      prev_wr = bus.Tx_wr;

      if (we) begin
         if (q.size() < DEPTH || pop) acc = 1'b1;
         else                         m_overflow = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(wd);

      bus.wr_en   = we;
      bus.wr_data = wd;
      bus.Tx_busy = busy;
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 8'h00);
   endtask

   task automatic drain(input int budget);
      int b;
      b = budget;
      while ((q.size() != 0 || u_st != U_IDLE) && b > 0) begin
         tick(1'b0, 8'h00);
         b--;
      end
      check("drain_pending", q.size() + ((u_st != U_IDLE) ? 1 : 0), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t       vec[10];
      logic [7:0] burst[4];
      int         base;
      int         n0;
      int         wr_tick;
      int         b;

      burst = '{8'hAA, 8'h55, 8'hCC, 8'h89};
      for (int i = 0; i < 9; i++)
         vec[i] = '{1'b1, 8'(i), (i < 8) ? i + 1 : 8, (i >= 7), 1'b0, (i == 8)};
      vec[9] = '{1'b0, 8'h00, 8, 1'b1, 1'b0, 1'b1};

      reset       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.Tx_busy = 1'b0;
      cfg_delay    = 2;
      cfg_len      = 20;
      no_ack       = 1'b0;
      force_busy   = 1'b0;
      spur_en      = 1'b0;
      chk_interval = 1'b0;
      cyc          = 0;
      pulses       = 0;
      last_pulse   = -1;
      model_reset();

      // Reset then idle
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("after_reset");

      // Single byte, ack 2 cycles after Tx_wr, busy for 20 cycles
      base    = pulses;
      wr_tick = cyc;
      tick(1'b1, 8'hAA);
      idle(30);
      check("single_pulses", pulses - base, 1);
      check("single_latency", last_pulse - wr_tick, 2);
      check("single_data", obs[obs.size() - 1], 8'hAA);
      check("single_count", bus.count, 0);
`ifdef UART_TX_FEEDER_STATS_EN
      check("single_tx_sent", bus.tx_sent, 16'd1);
`else
      check("single_tx_sent", bus.tx_sent, 16'd0);
`endif

      // Burst of four back-to-back writes
      cfg_len = 3;
      n0      = obs.size();
      for (int i = 0; i < 4; i++) tick(1'b1, burst[i]);
      drain(300);
      idle(2);
      check("burst_pulses", obs.size() - n0, 4);
      for (int i = 0; i < 4 && n0 + i < obs.size(); i++) check("burst_order", obs[n0 + i], burst[i]);
      check("burst_count", bus.count, 0);

      // Full / overflow with the uart held busy, table driven
      force_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(vec[i].wr_en, vec[i].wr_data);
         check("vec_count", bus.count, vec[i].exp_count);
         check("vec_full", bus.full, vec[i].exp_full);
         check("vec_empty", bus.empty, vec[i].exp_empty);
         check("vec_overflow", bus.overflow, vec[i].exp_ovf);
         check("vec_tx_wr", bus.Tx_wr, 0);
      end
      force_busy = 1'b0;
      n0 = obs.size();
      drain(600);
      idle(2);
      check("drain_pulses", obs.size() - n0, 8);
      for (int i = 0; i < 8 && n0 + i < obs.size(); i++) check("drain_order", obs[n0 + i], 8'(i));
      check("overflow_sticky", bus.overflow, 1);

      // Ack timeout: no response for three pulses, then acknowledge the fourth
      no_ack       = 1'b1;
      chk_interval = 1'b1;
      last_pulse   = -1;
      base         = pulses;
      n0           = obs.size();
      tick(1'b1, 8'h55);
      b = 0;
      while (pulses - base < 3 && b < 200) begin tick(1'b0, 8'h00); b++; end
      check("timeout_three_pulses", pulses - base, 3);
      no_ack = 1'b0;
      b = 0;
      while (pulses - base < 4 && b < 100) begin tick(1'b0, 8'h00); b++; end
      chk_interval = 1'b0;
      drain(100);
      idle(4);
      check("timeout_total_pulses", pulses - base, 4);
      for (int i = 0; i < 4 && n0 + i < obs.size(); i++) check("timeout_data", obs[n0 + i], 8'h55);
      check("timeout_count_after", bus.count, 0);

      // Randomized traffic, random ack delays and foreign busy periods
      cfg_delay = 0;
      cfg_len   = 0;
      spur_en   = 1'b1;
      repeat (1500) tick(($urandom_range(9) < 4), 8'($urandom));
      spur_en = 1'b0;
      drain(2000);
      idle(2);

      // Reset while a byte is in flight
      cfg_delay = 2;
      cfg_len   = 20;
      tick(1'b1, 8'h11);
      tick(1'b1, 8'h22);
      tick(1'b1, 8'h33);
      b = 0;
      while (u_st != U_BUSY && b < 50) begin tick(1'b0, 8'h00); b++; end
      check("reached_wait_done", u_st, U_BUSY);
      #2 reset = 1'b0;
      #1 check_reset_outputs("mid_reset");
      bus.wr_en   = 1'b0;
      bus.Tx_busy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      base = pulses;
      idle(30);
      check("post_reset_pulses", pulses - base, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
